// File: rtl/ibex_rvfi_trace_buf.sv
// ibex_rvfi_trace_buf: RVFI retirement records queued in a FIFO and streamed as 32-bit words; IBEX_TRACE_BUF_MEM_EN adds mem_addr/mem_wdata words
module ibex_rvfi_trace_buf #(
  parameter int DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trace_en_i,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_intr,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [31:0] rvfi_mem_wdata,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic [31:0] trace_data_o,
  output logic        trace_last_o,
  output logic [15:0] drop_cnt_o,
  output logic        full_o
);
`ifdef IBEX_TRACE_BUF_MEM_EN
  localparam int W = 6;
`else
  localparam int W = 4;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(W);
  typedef enum logic {EMPTY, STREAM} state_e;
  state_e st;
  logic [31:0] mem [DEPTH][W];
  logic [31:0] rec [W];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count, count_n;
  logic [WW-1:0] widx;
  logic lost, full_q, push, drop, pop, unused_bits;
  logic [15:0] drop_cnt;
  assign rec[0] = {rvfi_order[15:0], lost, rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_mem_wmask, rvfi_mem_rmask};
  assign rec[1] = rvfi_pc_rdata;
  assign rec[2] = rvfi_insn;
  assign rec[3] = rvfi_rd_wdata;
`ifdef IBEX_TRACE_BUF_MEM_EN
  assign rec[4] = rvfi_mem_addr;
  assign rec[5] = rvfi_mem_wdata;
  assign unused_bits = ^rvfi_order[63:16];
`else
  assign unused_bits = ^{rvfi_order[63:16], rvfi_mem_addr, rvfi_mem_wdata};
`endif
  // push/drop look only at the registered count, so a same-cycle pop never frees room
  assign push = trace_en_i && rvfi_valid && count != (AW+1)'(DEPTH);
  assign drop = trace_en_i && rvfi_valid && count == (AW+1)'(DEPTH);
  assign trace_valid_o = st == STREAM;
  assign trace_last_o = trace_valid_o && widx == WW'(W-1);
  assign pop = trace_last_o && trace_ready_i;
  assign trace_data_o = trace_valid_o ? mem[rptr][widx] : '0;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  assign full_o = full_q;
  assign drop_cnt_o = drop_cnt;
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= rec;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st       <= EMPTY;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      widx     <= '0;
      lost     <= 1'b0;
      full_q   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      st     <= count_n != '0 ? STREAM : EMPTY;
      count  <= count_n;
      full_q <= count_n == (AW+1)'(DEPTH);
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (trace_valid_o && trace_ready_i) widx <= trace_last_o ? '0 : widx + WW'(1);
      if (drop) lost <= 1'b1;
      else if (push) lost <= 1'b0;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// tb_ibex_rvfi_trace_buf: directed and random stimulus against a word-queue reference model
module tb_ibex_rvfi_trace_buf;
  localparam int DEPTH = 16;
`ifdef IBEX_TRACE_BUF_MEM_EN
  localparam int W = 6;
`else
  localparam int W = 4;
`endif
  logic clk_i = 0, rst_i = 1, trace_en_i = 0, rvfi_valid = 0, trace_ready_i = 0;
  logic [63:0] rvfi_order = 0;
  logic [31:0] rvfi_pc_rdata = 0, rvfi_insn = 0, rvfi_rd_wdata = 0, rvfi_mem_addr = 0, rvfi_mem_wdata = 0;
  logic rvfi_trap = 0, rvfi_intr = 0;
  logic [4:0] rvfi_rd_addr = 0;
  logic [3:0] rvfi_mem_rmask = 0, rvfi_mem_wmask = 0;
  logic trace_valid_o, trace_last_o, full_o;
  logic [31:0] trace_data_o;
  logic [15:0] drop_cnt_o;

  ibex_rvfi_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trace_en_i(trace_en_i), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_wdata(rvfi_mem_wdata), .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i), .trace_data_o(trace_data_o), .trace_last_o(trace_last_o),
    .drop_cnt_o(drop_cnt_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  logic [32:0] q[$];
  int n_assert = 0, n_fail = 0, m_drop = 0;
  bit m_lost = 0, m_full = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Records are flattened into a word queue; records held = ceil(words / W).
  task automatic edge_model();
    int occ;
    logic [31:0] w [6];
    occ = (q.size() + W - 1) / W;
    if (rst_i) begin
      q.delete();
      m_lost = 0;
      m_drop = 0;
    end else begin
      if (q.size() != 0 && trace_ready_i) void'(q.pop_front());
      if (trace_en_i && rvfi_valid) begin
        if (occ < DEPTH) begin
          w[0] = (32'(rvfi_order[15:0]) << 16) | (32'(m_lost) << 15) | (32'(rvfi_trap) << 14) |
                 (32'(rvfi_intr) << 13) | (32'(rvfi_rd_addr) << 8) | (32'(rvfi_mem_wmask) << 4) |
                 32'(rvfi_mem_rmask);
          w[1] = rvfi_pc_rdata; w[2] = rvfi_insn; w[3] = rvfi_rd_wdata;
          w[4] = rvfi_mem_addr; w[5] = rvfi_mem_wdata;
          for (int k = 0; k < W; k++) q.push_back({k == W - 1, w[k]});
          m_lost = 0;
        end else begin
          if (m_drop < 16'hFFFF) m_drop++;
          m_lost = 1;
        end
      end
    end
    m_full = (q.size() + W - 1) / W == DEPTH;
  endtask

  task automatic check_all();
    chk("valid", trace_valid_o, q.size() != 0);
    chk("data", trace_data_o, q.size() != 0 ? q[0][31:0] : 32'h0);
    chk("last", trace_last_o, q.size() != 0 ? q[0][32] : 1'b0);
    chk("full", full_o, m_full);
    chk("drop_cnt", drop_cnt_o, m_drop);
  endtask

  task automatic tick();
    @(posedge clk_i);
    edge_model();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic rnd();
    rvfi_order++;
    rvfi_pc_rdata = $urandom; rvfi_insn = $urandom; rvfi_rd_wdata = $urandom;
    rvfi_mem_addr = $urandom; rvfi_mem_wdata = $urandom;
    rvfi_trap = 1'($urandom); rvfi_intr = 1'($urandom); rvfi_rd_addr = 5'($urandom);
    rvfi_mem_rmask = 4'($urandom); rvfi_mem_wmask = 4'($urandom);
  endtask

  initial begin
    int d0;
    tick(); tick();
    rst_i = 0;
    chk("reset_valid", trace_valid_o, 0);
    // single retire, ready high
    trace_en_i = 1; trace_ready_i = 1; rvfi_valid = 1;
    rvfi_order = 5; rvfi_pc_rdata = 32'h80; rvfi_insn = 32'h00100093; rvfi_rd_addr = 1; rvfi_rd_wdata = 1;
    tick(); rvfi_valid = 0;
    chk("t1_w0", trace_data_o, 32'h00050100);
    tick(); chk("t1_w1", trace_data_o, 32'h80);
    tick(); chk("t1_w2", trace_data_o, 32'h00100093);
    tick(); chk("t1_w3", trace_data_o, 32'h1);
    chk("t1_last", trace_last_o, W == 4);
    repeat (W - 3) tick();
    chk("t1_idle", trace_valid_o, 0);
    // overflow with ready low
    trace_ready_i = 0; rvfi_valid = 1;
    for (int i = 0; i < DEPTH + 3; i++) begin rnd(); tick(); end
    rvfi_valid = 0;
    chk("t2_full", full_o, 1);
    chk("t2_drops", drop_cnt_o, 3);
    trace_ready_i = 1;
    repeat (DEPTH * W) tick();
    chk("t2_drained", trace_valid_o, 0);
    rnd(); rvfi_valid = 1; tick(); rvfi_valid = 0;
    chk("t2_lost_hdr", trace_data_o[15], 1);
    repeat (W) tick();
    // back-pressure
    for (int i = 0; i < 40; i++) begin
      trace_ready_i = i[0];
      rvfi_valid = (i % 5) == 0;
      if (rvfi_valid) rnd();
      tick();
    end
    rvfi_valid = 0; trace_ready_i = 1;
    repeat (3 * W) tick();
    chk("t3_drained", trace_valid_o, 0);
    // push while full coinciding with pop of head's last word
    trace_ready_i = 0; rvfi_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin rnd(); tick(); end
    rvfi_valid = 0; trace_ready_i = 1;
    repeat (W - 1) tick();
    chk("t4_at_last", trace_last_o, 1);
    d0 = drop_cnt_o;
    rnd(); rvfi_valid = 1; tick(); rvfi_valid = 0;
    chk("t4_drop", drop_cnt_o, 16'(d0 + 1));
    chk("t4_not_full", full_o, 0);
    // reset mid-record
    tick(); tick();
    rst_i = 1; rnd(); rvfi_valid = 1; tick();
    rst_i = 0; rvfi_valid = 0;
    chk("t5_valid", trace_valid_o, 0);
    chk("t5_data", trace_data_o, 0);
    chk("t5_drop", drop_cnt_o, 0);
    rnd(); rvfi_valid = 1; tick(); rvfi_valid = 0;
    chk("t5_hdr_lost", trace_data_o[15], 0);
    chk("t5_hdr_order", trace_data_o[31:16], rvfi_order[15:0]);
    repeat (W) tick();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      trace_en_i = $urandom_range(0, 7) != 0;
      rvfi_valid = 1'($urandom);
      trace_ready_i = $urandom_range(0, 3) != 0;
      rnd();
      tick();
    end
    trace_en_i = 1; rvfi_valid = 0; trace_ready_i = 1;
    repeat (DEPTH * W + W) tick();
    chk("t6_drained", trace_valid_o, 0);
`ifdef IBEX_TRACE_BUF_MEM_EN
    rnd(); rvfi_mem_wmask = 4'hF; rvfi_mem_addr = 32'h1000; rvfi_mem_wdata = 32'hDEADBEEF;
    rvfi_valid = 1; tick(); rvfi_valid = 0;
    chk("t7_wmask", trace_data_o[7:4], 4'hF);
    repeat (4) tick();
    chk("t7_w4", trace_data_o, 32'h1000);
    tick();
    chk("t7_w5", trace_data_o, 32'hDEADBEEF);
    chk("t7_last", trace_last_o, 1);
    tick();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ibex_rvfi_trace_buf.md
# ibex_rvfi_trace_buf

Retirement trace buffer sitting directly downstream of the tracing core top. It consumes the per-instruction RVFI retirement signals and captures each retired instruction as a fixed-length record in a FIFO. It streams records out as 32-bit words over a valid/ready interface to an off-core trace sink (DMA, UART bridge or debug memory). Records that arrive while the FIFO is full are dropped, counted and flagged.

## Interface
- `DEPTH`, 16: record FIFO capacity in records; power of two, ≥2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `trace_en_i` in 1: capture enable; when low, `rvfi_valid` is ignored (not counted as drop).
- `rvfi_valid` in 1: instruction retired this cycle.
- `rvfi_order` in 64: retirement order; low 16 bits used.
- `rvfi_pc_rdata` in 32: PC of retired instruction.
- `rvfi_insn` in 32: instruction word.
- `rvfi_trap`, `rvfi_intr` in 1 each: trap / first instruction of handler.
- `rvfi_rd_addr` in 5, `rvfi_rd_wdata` in 32: destination register and value.
- `rvfi_mem_rmask`, `rvfi_mem_wmask` in 4 each; `rvfi_mem_addr`, `rvfi_mem_wdata` in 32 each.
- `trace_valid_o` out 1: output word valid.
- `trace_ready_i` in 1: sink accepts word.
- `trace_data_o` out 32: output word.
- `trace_last_o` out 1: current word is last of record.
- `drop_cnt_o` out 16: dropped-record count, saturating.
- `full_o` out 1: FIFO holds DEPTH records.

## Operation
- Record words (W = 4, or 6 with macro):
  - w0 header: [31:16] order[15:0], [15] lost, [14] trap, [13] intr, [12:8] rd_addr, [7:4] mem_wmask, [3:0] mem_rmask.
  - w1 pc.
  - w2 insn.
  - w3 rd_wdata.
  - w4 mem_addr and w5 mem_wdata (macro only).
- Push: `trace_en_i && rvfi_valid && count<DEPTH` sampled at the start of the cycle. A pop in the same cycle does not free space for that push.
- Drop: `trace_en_i && rvfi_valid && count==DEPTH`.
  - `drop_cnt_o` increments, saturating at 0xFFFF.
  - Sticky `lost` flag is set.
- `lost` is written into the header of the next pushed record, then cleared the same cycle. A drop and a push cannot coincide.
- Serializer:
  - Word index counter `widx` in 0..W-1 selects the word of the head record.
  - `trace_valid_o = count!=0`.
  - `trace_last_o = trace_valid_o && widx==W-1`.
  - On `valid&&ready`: if last, pop head and set `widx`=0, else `widx`+1.
- States: EMPTY (count 0), STREAM (count>0). Serializer stays in STREAM back-to-back across records without idle cycles.
- Valid/ready rules:
  - Once `trace_valid_o` is high it stays high, with `trace_data_o` stable, until accepted.
  - `trace_data_o` is 0 when `trace_valid_o` is low.
- `trace_en_i` deassertion never truncates a record already in the FIFO.
- Read/write pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

## Timing
- Reset (`rst_i` high at a clock edge): count, pointers, `widx`, `lost`, `drop_cnt_o` all cleared.
  - Next cycle: `trace_valid_o`=0, `trace_last_o`=0, `trace_data_o`=0, `full_o`=0, `drop_cnt_o`=0.
  - A record mid-stream is discarded.
  - `rvfi_valid` in the reset cycle is ignored.
- Capture latency: record pushed at edge N is visible on `trace_valid_o`/`trace_data_o` (w0) in cycle N+1 when the FIFO was empty.
- Throughput: one word per cycle with `trace_ready_i` held high; one record every W cycles.
- `full_o` and `drop_cnt_o` are registered and update the cycle after the causing edge.
- No combinational path from `trace_ready_i` to `full_o`.

## Configuration
- `IBEX_TRACE_BUF_MEM_EN` defined:
  - W=6; w4=`rvfi_mem_addr`, w5=`rvfi_mem_wdata` stored and streamed.
  - FIFO entry width 192 bits.
- Not defined:
  - W=4; `rvfi_mem_addr`/`rvfi_mem_wdata` unused (tied to an unused sink); entry width 128 bits.
  - Header mask fields still populated.

## Test plan
- Single retire (order=5, pc=0x80, insn=0x00100093, rd=1, wdata=1), ready high → words 0x00050100, 0x80, 0x00100093, 0x1 on four consecutive cycles, `trace_last_o` on the 4th; valid drops after.
- Ready held low, DEPTH+3 retires → `full_o`=1 after DEPTH pushes, `drop_cnt_o`=3. Then release ready → DEPTH records stream out in order; headers have bit15=0. Next retire's header has bit15=1.
- Back-pressure: toggle ready every other cycle → each word is held stable until accepted; no words lost or duplicated; order field increments.
- Push while full with simultaneous pop of last word → push dropped, `drop_cnt_o`+1, count becomes DEPTH-1.
- Assert `rst_i` mid-record (after w1 accepted) → next cycle all outputs 0; a fresh retire streams from w0 with lost=0.
- With `IBEX_TRACE_BUF_MEM_EN`: store (wmask=0xF, addr=0x1000, wdata=0xDEADBEEF) → 6 words; header[7:4]=0xF, w4=0x1000, w5=0xDEADBEEF, `trace_last_o` on w5.
